// File: rtl/scomp_term_accumulator.sv
// Accumulates NUM_TERMS thermometer ones-counts per frame as signed terms
// t = 2*c - N, emitting a one-cycle sum_valid pulse with the registered frame sum.
module scomp_term_accumulator #(
  parameter int SERIAL_INPUT_LENGTH = 6,
  parameter int NUM_TERMS = 4,
  localparam int CNT_W = $clog2(SERIAL_INPUT_LENGTH) + 1,
  localparam int SUM_W = CNT_W + 1 + $clog2(NUM_TERMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_count,
  output logic             sum_valid,
  output logic [SUM_W-1:0] sum_out,
  output logic             busy,
  output logic             range_err
);

  localparam int IDX_W = $clog2(NUM_TERMS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [SUM_W-1:0] acc;
  logic [IDX_W-1:0] idx;

  logic             over;
  logic [CNT_W-1:0] count_clamped;
  logic [SUM_W-1:0] term;
  logic [SUM_W-1:0] acc_sum;
  logic             last_term;

  // Modular subtraction in SUM_W bits yields the two's-complement term directly.
  assign over          = in_count > CNT_W'(SERIAL_INPUT_LENGTH);
  assign count_clamped = over ? CNT_W'(SERIAL_INPUT_LENGTH) : in_count;
  assign term          = SUM_W'({count_clamped, 1'b0}) - SUM_W'(SERIAL_INPUT_LENGTH);
  assign acc_sum       = acc + term;
  assign last_term     = (idx == IDX_W'(NUM_TERMS - 1));

  // A clear landing on the DONE cycle swallows that cycle's pulse.
  assign sum_valid = (state == S_DONE) && !clear;
  assign busy      = (state == S_ACCUM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      idx       <= '0;
      sum_out   <= '0;
      range_err <= 1'b0;
    end else if (clear) begin
      state     <= S_IDLE;
      acc       <= '0;
      idx       <= '0;
      range_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (in_valid) begin
            // First term of a frame; from DONE this gives bubble-free back-to-back frames.
            acc       <= term;
            idx       <= IDX_W'(1);
            range_err <= over;
            if (NUM_TERMS == 1) begin
              state   <= S_DONE;
              sum_out <= term;
            end else begin
              state <= S_ACCUM;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc       <= acc_sum;
            idx       <= idx + IDX_W'(1);
            range_err <= range_err | over;
            if (last_term) begin
              state   <= S_DONE;
              sum_out <= acc_sum;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scomp_term_accumulator.sv
// Bench for scomp_term_accumulator: vector table, directed corner sequences and
// randomized traffic checked against a frame-level reference model.
module tb_scomp_term_accumulator;

  localparam int N     = 6;
  localparam int K     = 4;
  localparam int CNT_W = $clog2(N) + 1;
  localparam int SUM_W = CNT_W + 1 + $clog2(K);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [CNT_W-1:0] in_count = '0;
  logic             sum_valid;
  logic [SUM_W-1:0] sum_out;
  logic             busy;
  logic             range_err;

  scomp_term_accumulator #(
    .SERIAL_INPUT_LENGTH(N),
    .NUM_TERMS(K)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_count(in_count),
    .sum_valid(sum_valid),
    .sum_out(sum_out),
    .busy(busy),
    .range_err(range_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulse_cyc[$];
  int pulse_val[$];

  // reference model: list of accepted terms of the open frame
  int  m_terms[$];
  bit  m_pulse = 1'b0;
  int  m_sum = 0;
  bit  m_rerr = 1'b0;
  logic [SUM_W-1:0] exp_q[$];

  typedef struct {
    bit v;
    int c;
    bit clr;
    bit exp_valid;
    int exp_sum;
    bit exp_busy;
    bit exp_rerr;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sum_s();
    return int'($signed(sum_out));
  endfunction

  // driver
  task automatic drive(input bit v, input int c, input bit clr, input bit rn);
    @(negedge clk);
    in_valid = v;
    in_count = CNT_W'(c);
    clear    = clr;
    rst      = rn;
    #1;
  endtask

  // compare DUT against the model with the current inputs applied
  task automatic model_check();
    logic [SUM_W-1:0] e;
    chk("m_sum_valid", int'(sum_valid), int'(m_pulse && !clear));
    chk("m_busy", int'(busy), int'(m_terms.size() != 0));
    chk("m_range_err", int'(range_err), int'(m_rerr));
    chk("m_sum_out", sum_s(), m_sum);
    if (sum_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_val.push_back(sum_s());
    end
    if (m_pulse && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (!clear) chk("sb_pulse_sum", sum_s(), int'($signed(e)));
    end
  endtask

  // advance one edge and update the model from the inputs seen at that edge
  task automatic tick();
    int cc;
    int s;
    bit v;
    int c;
    bit clr;
    bit rn;
    v = in_valid; c = int'(in_count); clr = clear; rn = rst;
    @(posedge clk);
    cyc++;
    if (!rn) begin
      m_terms.delete();
      m_pulse = 1'b0;
      m_sum   = 0;
      m_rerr  = 1'b0;
      exp_q.delete();
    end else if (clr) begin
      m_terms.delete();
      m_pulse = 1'b0;
      m_rerr  = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (v) begin
        cc = (c > N) ? N : c;
        if (m_terms.size() == 0) m_rerr = (c > N);
        else m_rerr = m_rerr | (c > N);
        m_terms.push_back(2 * cc - N);
        if (m_terms.size() == K) begin
          s = 0;
          foreach (m_terms[i]) s += m_terms[i];
          m_sum   = s;
          m_pulse = 1'b1;
          exp_q.push_back(SUM_W'(s));
          m_terms.delete();
        end
      end
    end
  endtask

  task automatic step(input bit v, input int c, input bit clr, input bit rn);
    drive(v, c, clr, rn);
    model_check();
    tick();
  endtask

  function automatic vec_t mk(bit v, int c, bit clr, bit ev, int es, bit eb, bit er);
    vec_t r;
    r.v = v; r.c = c; r.clr = clr;
    r.exp_valid = ev; r.exp_sum = es; r.exp_busy = eb; r.exp_rerr = er;
    return r;
  endfunction

  initial begin
    int p0;
    bit gap_v[8];
    bit gap_busy[8];

    // basic frame 4,1,6,0 -> -2
    vecs[0]  = mk(1, 4, 0, 0,   0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0,   0, 1, 0);
    vecs[2]  = mk(1, 6, 0, 0,   0, 1, 0);
    vecs[3]  = mk(1, 0, 0, 0,   0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 1,  -2, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0,  -2, 0, 0);
    // extremes +24 then -24, second frame starts in the DONE cycle
    vecs[6]  = mk(1, 6, 0, 0,  -2, 0, 0);
    vecs[7]  = mk(1, 6, 0, 0,  -2, 1, 0);
    vecs[8]  = mk(1, 6, 0, 0,  -2, 1, 0);
    vecs[9]  = mk(1, 6, 0, 0,  -2, 1, 0);
    vecs[10] = mk(1, 0, 0, 1,  24, 0, 0);
    vecs[11] = mk(1, 0, 0, 0,  24, 1, 0);
    vecs[12] = mk(1, 0, 0, 0,  24, 1, 0);
    vecs[13] = mk(1, 0, 0, 0,  24, 1, 0);
    vecs[14] = mk(0, 0, 0, 1, -24, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, -24, 0, 0);
    // out-of-range first term 7 clamps to 6
    vecs[16] = mk(1, 7, 0, 0, -24, 0, 0);
    vecs[17] = mk(1, 6, 0, 0, -24, 1, 1);
    vecs[18] = mk(1, 6, 0, 0, -24, 1, 1);
    vecs[19] = mk(1, 6, 0, 0, -24, 1, 1);
    vecs[20] = mk(0, 0, 0, 1,  24, 0, 1);
    // new in-range frame clears the flag, then clear aborts it
    vecs[21] = mk(1, 3, 0, 0,  24, 0, 1);
    vecs[22] = mk(0, 0, 0, 0,  24, 1, 0);
    vecs[23] = mk(1, 6, 1, 0,  24, 1, 0);
    vecs[24] = mk(0, 0, 0, 0,  24, 0, 0);

    // reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sum_valid", int'(sum_valid), 0);
    chk("reset_sum_out", sum_s(), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_range_err", int'(range_err), 0);

    // vector table; first row is accepted on the first edge with rst high
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].c, vecs[i].clr, 1'b1);
      model_check();
      chk($sformatf("vec%0d_sum_valid", i), int'(sum_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_sum_out", i), sum_s(), vecs[i].exp_sum);
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_range_err", i), int'(range_err), int'(vecs[i].exp_rerr));
      tick();
    end

    // back-to-back frames of t=0 with valid held high through DONE
    p0 = pulse_cyc.size();
    repeat (8) step(1, 3, 0, 1);
    repeat (2) step(0, 0, 0, 1);
    chk("b2b_pulses", pulse_cyc.size() - p0, 2);
    if (pulse_cyc.size() - p0 == 2) begin
      chk("b2b_spacing", pulse_cyc[p0 + 1] - pulse_cyc[p0], 4);
      chk("b2b_sum0", pulse_val[p0], 0);
      chk("b2b_sum1", pulse_val[p0 + 1], 0);
    end

    // gapped input 5,_,_,5,_,5,5 -> +16
    gap_v    = '{1, 0, 0, 1, 0, 1, 1, 0};
    gap_busy = '{0, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      drive(gap_v[i], gap_v[i] ? 5 : 13, 0, 1);
      model_check();
      chk($sformatf("gap%0d_busy", i), int'(busy), int'(gap_busy[i]));
      if (i == 7) begin
        chk("gap_sum_valid", int'(sum_valid), 1);
        chk("gap_sum_out", sum_s(), 16);
      end
      tick();
    end

    // clear mid-frame, term in the clear cycle discarded, then clean frame
    p0 = pulse_cyc.size();
    step(1, 2, 0, 1);
    step(1, 2, 0, 1);
    step(1, 6, 1, 1);
    step(1, 6, 0, 1);
    step(1, 6, 0, 1);
    step(1, 6, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("clr_pulses", pulse_cyc.size() - p0, 1);
    if (pulse_cyc.size() - p0 == 1) chk("clr_sum", pulse_val[p0], 12);

    // clear landing on the DONE cycle suppresses the pulse
    repeat (4) step(1, 5, 0, 1);
    drive(0, 0, 1, 1);
    model_check();
    chk("clr_done_sum_valid", int'(sum_valid), 0);
    tick();
    step(0, 0, 0, 1);

    // reset mid-frame with range_err set and sum_out nonzero
    p0 = pulse_cyc.size();
    step(1, 9, 0, 1);
    step(1, 5, 0, 1);
    step(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    model_check();
    chk("rst_mid_sum_valid", int'(sum_valid), 0);
    chk("rst_mid_sum_out", sum_s(), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_range_err", int'(range_err), 0);
    tick();
    repeat (4) step(0, 0, 0, 1);
    chk("rst_mid_pulses", pulse_cyc.size() - p0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 15),
           $urandom_range(0, 99) < 3, !($urandom_range(0, 199) < 2));
    end
    repeat (3) step(0, 0, 0, 1);
    chk("sb_drained", exp_q.size(), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
